// File: rtl/alu_cmd_pkg.sv
// Shared encodings for the ALU command assembler: opcodes, command word field layout,
// frame-assembly states and a helper that packs a command word.
package alu_cmd_pkg;

    localparam int CMD_W  = 10;
    localparam int NIB_W  = 4;
    localparam int D1_LSB = 0;
    localparam int D2_LSB = 4;
    localparam int OP_LSB = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_A   = 2'd1,
        S_B   = 2'd2
    } state_e;

    function automatic logic [CMD_W-1:0] pack_cmd(input op_e op, input logic [NIB_W-1:0] d2,
                                                  input logic [NIB_W-1:0] d1);
        logic [CMD_W-1:0] c;
        c = '0;
        c[OP_LSB +: 2]     = op;
        c[D2_LSB +: NIB_W] = d2;
        c[D1_LSB +: NIB_W] = d1;
        return c;
    endfunction

endpackage

// File: rtl/alu_cmd_timer.sv
// Inter-nibble idle counter. Fires o_expire on the TIMEOUT-th consecutive enabled cycle;
// TIMEOUT=0 disables it entirely.
module alu_cmd_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [TW-1:0] r_cnt;

    // Expiry is combinational so the abort lands on the same edge as the last idle cycle.
    assign o_expire = (TIMEOUT != 0) && i_enable && (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cnt <= '0;
        else if (i_clear || o_expire)
            r_cnt <= '0;
        else if (i_enable)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/alu_cmd_assembler.sv
// Assembles {header,data1,data2} nibble frames into 10-bit ALU commands for the FIFO
// write side; bad-header, divide-by-zero and timed-out frames are dropped and counted.
module alu_cmd_assembler
    import alu_cmd_pkg::*;
#(
    parameter int TIMEOUT    = 16,
    parameter bit CHECK_DIV0 = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NIB_W-1:0] i_nib_data,
    input  logic             i_nib_valid,
    output logic             o_nib_ready,
    output logic [CMD_W-1:0] o_cmd_data,
    output logic             o_cmd_valid,
    input  logic             i_cmd_ready,
    output logic             o_err_hdr,
    output logic             o_err_div0,
    output logic             o_err_timeout,
    output logic [CNT_W-1:0] o_drop_cnt
);
    state_e           r_state, w_state_nxt;
    op_e              r_op;
    logic [NIB_W-1:0] r_d1;
    logic [CMD_W-1:0] r_cmd_data;
    logic             r_cmd_valid;
    logic             r_err_hdr, r_err_div0, r_err_timeout;
    logic [CNT_W-1:0] r_drop_cnt;

    logic w_xfer, w_hdr_bad, w_div0, w_load, w_lat_op, w_lat_d1, w_drop;
    logic w_tmr_clear, w_tmr_en, w_expire;

    // Final nibble is held off while a word is parked, so the output register is never overwritten.
    assign o_nib_ready = (r_state != S_B) || !r_cmd_valid || i_cmd_ready;
    assign w_xfer      = i_nib_valid && o_nib_ready;

    assign w_tmr_clear = w_xfer || (r_state == S_HDR);
    assign w_tmr_en    = ((r_state == S_A) || ((r_state == S_B) && o_nib_ready)) && !w_xfer;

    alu_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_bad   = 1'b0;
        w_div0      = 1'b0;
        w_load      = 1'b0;
        w_lat_op    = 1'b0;
        w_lat_d1    = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_xfer) begin
                    if (i_nib_data[3:2] != 2'b00) begin
                        w_hdr_bad = 1'b1;
                    end else begin
                        w_lat_op    = 1'b1;
                        w_state_nxt = S_A;
                    end
                end
            end
            S_A: begin
                if (w_xfer) begin
                    w_lat_d1    = 1'b1;
                    w_state_nxt = S_B;
                end else if (w_expire) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_B: begin
                if (w_xfer) begin
                    if (CHECK_DIV0 && (r_op == OP_DIV) && (i_nib_data == '0))
                        w_div0 = 1'b1;
                    else
                        w_load = 1'b1;
                    w_state_nxt = S_HDR;
                end else if (w_expire) begin
                    w_state_nxt = S_HDR;
                end
            end
            default: w_state_nxt = S_HDR;
        endcase
    end

    assign w_drop = w_hdr_bad || w_div0 || w_expire;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_HDR;
            r_op    <= OP_ADD;
            r_d1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_lat_op) r_op <= op_e'(i_nib_data[1:0]);
            if (w_lat_d1) r_d1 <= i_nib_data;
        end
    end

    // A reload on the accepting edge keeps valid high, giving back-to-back words.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cmd_data  <= '0;
            r_cmd_valid <= 1'b0;
        end else if (w_load) begin
            r_cmd_data  <= pack_cmd(r_op, i_nib_data, r_d1);
            r_cmd_valid <= 1'b1;
        end else if (r_cmd_valid && i_cmd_ready) begin
            r_cmd_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err_hdr     <= 1'b0;
            r_err_div0    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_err_hdr     <= w_hdr_bad;
            r_err_div0    <= w_div0;
            r_err_timeout <= w_expire;
            if (w_drop && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign o_cmd_data    = r_cmd_data;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_err_hdr     = r_err_hdr;
    assign o_err_div0    = r_err_div0;
    assign o_err_timeout = r_err_timeout;
    assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_alu_cmd_assembler.sv
// Directed bench for alu_cmd_assembler: a frame-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_alu_cmd_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] nib = 4'h0;
    logic       nv  = 1'b0;
    logic       cr  = 1'b1;

    logic       o_nib_ready, o_cmd_valid, o_err_hdr, o_err_div0, o_err_timeout;
    logic [9:0] o_cmd_data;
    logic [7:0] o_drop_cnt;
    logic       n_nib_ready, n_cmd_valid, n_err_hdr, n_err_div0, n_err_timeout;
    logic [9:0] n_cmd_data;
    logic [7:0] n_drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    alu_cmd_assembler u_dut (
        .i_clk(clk), .i_reset(rst), .i_nib_data(nib), .i_nib_valid(nv),
        .o_nib_ready(o_nib_ready), .o_cmd_data(o_cmd_data), .o_cmd_valid(o_cmd_valid),
        .i_cmd_ready(cr), .o_err_hdr(o_err_hdr), .o_err_div0(o_err_div0),
        .o_err_timeout(o_err_timeout), .o_drop_cnt(o_drop_cnt)
    );

    alu_cmd_assembler #(.CHECK_DIV0(1'b0)) u_dut_nd (
        .i_clk(clk), .i_reset(rst), .i_nib_data(nib), .i_nib_valid(nv),
        .o_nib_ready(n_nib_ready), .o_cmd_data(n_cmd_data), .o_cmd_valid(n_cmd_valid),
        .i_cmd_ready(cr), .o_err_hdr(n_err_hdr), .o_err_div0(n_err_div0),
        .o_err_timeout(n_err_timeout), .o_drop_cnt(n_drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: collected nibbles of the open frame, idle count, held word.
    logic [3:0] frame[$];
    int         idle;
    logic [9:0] m_word;
    bit         m_valid, m_ehdr, m_ediv, m_eto;
    int         m_drops;
    bit         x_xfer, x_acc, x_load, x_drop;
    logic [9:0] x_word;
    logic [9:0] acc[$];

    function automatic bit exp_rdy();
        return (frame.size() < 2) || !m_valid || cr;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame.delete();
            idle = 0; m_word = '0; m_valid = 0; m_drops = 0;
            m_ehdr = 0; m_ediv = 0; m_eto = 0;
        end else begin
            x_xfer = nv && exp_rdy();
            x_acc  = m_valid && cr;
            x_load = 0; x_drop = 0;
            m_ehdr = 0; m_ediv = 0; m_eto = 0;
            x_word = '0;
            if (x_xfer) begin
                idle = 0;
                if (frame.size() == 0) begin
                    if (nib >= 4'd4) begin m_ehdr = 1; x_drop = 1; end
                    else frame.push_back(nib);
                end else if (frame.size() == 1) begin
                    frame.push_back(nib);
                end else begin
                    if (frame[0] == 4'd3 && nib == 4'd0) begin m_ediv = 1; x_drop = 1; end
                    else begin
                        x_word = 10'(frame[0]) * 256 + 10'(nib) * 16 + 10'(frame[1]);
                        x_load = 1;
                    end
                    frame.delete();
                end
            end else if (frame.size() > 0 && exp_rdy()) begin
                idle++;
                if (idle == 16) begin
                    m_eto = 1; x_drop = 1; frame.delete(); idle = 0;
                end
            end
            if (x_load) begin m_word = x_word; m_valid = 1; end
            else if (x_acc) m_valid = 0;
            if (x_drop && m_drops < 255) m_drops++;
        end
    end

    always @(negedge clk) begin
        logic [22:0] a, e;
        a = {o_nib_ready, o_cmd_valid, o_cmd_data, o_err_hdr, o_err_div0, o_err_timeout, o_drop_cnt};
        e = {exp_rdy(), m_valid, m_word, m_ehdr, m_ediv, m_eto, 8'(m_drops)};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t {rdy,vld,data,ehdr,ediv,eto,cnt} got %h want %h", $time, a, e);
        end
        if (o_cmd_valid && cr) acc.push_back(o_cmd_data);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] d);
        bit ok = 0;
        nib = d; nv = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); ok = o_nib_ready;
            @(posedge clk);
        end
        #1 nv = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL send_handshake: nibble %h got no ready want ready within 40 cycles", d);
        end
    endtask

    task automatic idle_cycles(input int n);
        nv = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", o_cmd_valid, 0);
        chk("rst_data", o_cmd_data, 0);
        chk("rst_cnt", o_drop_cnt, 0);
        chk("rst_ready", o_nib_ready, 1);
        @(posedge clk); #1;

        send(4'h1); send(4'h5); send(4'h3);
        @(negedge clk);
        chk("t1_valid", o_cmd_valid, 1);
        chk("t1_data", o_cmd_data, 10'h135);
        @(posedge clk); #1;

        send(4'h6);
        @(negedge clk);
        chk("t2_err_hdr", o_err_hdr, 1);
        chk("t2_cnt", o_drop_cnt, 1);
        chk("t2_novalid", o_cmd_valid, 0);
        @(posedge clk); #1;
        send(4'h0); send(4'h2); send(4'h2);
        @(negedge clk);
        chk("t2_data", o_cmd_data, 10'h022);
        @(posedge clk); #1;

        send(4'h3); send(4'h7); send(4'h0);
        @(negedge clk);
        chk("t3_err_div0", o_err_div0, 1);
        chk("t3_novalid", o_cmd_valid, 0);
        chk("t3_cnt", o_drop_cnt, 2);
        chk("t3_nd_valid", n_cmd_valid, 1);
        chk("t3_nd_data", n_cmd_data, 10'h307);
        @(posedge clk); #1;

        cr = 1'b0;
        acc.delete();
        send(4'h0); send(4'h1); send(4'h1);
        send(4'h1); send(4'h2);
        nib = 4'h2; nv = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall_ready", o_nib_ready, 0);
            chk("t4_hold_data", o_cmd_data, 10'h011);
        end
        @(posedge clk); #1 cr = 1'b1;
        @(posedge clk); #1 nv = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_acc_n", acc.size(), 2);
        if (acc.size() == 2) begin
            chk("t4_acc0", acc[0], 10'h011);
            chk("t4_acc1", acc[1], 10'h122);
        end
        @(posedge clk); #1;

        send(4'h2); send(4'h4);
        idle_cycles(16);
        @(negedge clk);
        chk("t5_err_to", o_err_timeout, 1);
        chk("t5_cnt", o_drop_cnt, 3);
        @(posedge clk); #1;
        send(4'h2); send(4'h3); send(4'h3);
        @(negedge clk);
        chk("t5_data", o_cmd_data, 10'h233);
        @(posedge clk); #1;
        send(4'h2); send(4'h4);
        idle_cycles(15);
        send(4'h5);
        @(negedge clk);
        chk("t5_late_nib_no_to", o_err_timeout, 0);
        chk("t5_late_data", o_cmd_data, 10'h254);
        chk("t5_late_cnt", o_drop_cnt, 3);
        @(posedge clk); #1;

        cr = 1'b0;
        send(4'h0); send(4'h1); send(4'h1);
        send(4'h1); send(4'h2);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", o_cmd_valid, 0);
        chk("t6_rst_cnt", o_drop_cnt, 0);
        @(posedge clk); #1 rst = 1'b0; cr = 1'b1;
        send(4'h1); send(4'h2); send(4'h3);
        @(negedge clk);
        chk("t6_valid", o_cmd_valid, 1);
        chk("t6_data", o_cmd_data, 10'h132);
        @(posedge clk); #1;

        for (int k = 0; k < 260; k++) send(4'hC);
        @(negedge clk);
        chk("sat_cnt", o_drop_cnt, 8'hFF);
        chk("sat_err_hdr", o_err_hdr, 1);
        @(posedge clk); #1;
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
